// File: rtl/rr_bank_scheduler.sv
// Round-robin scheduler: each cycle every ready bank grants up to NPORTS of the
// valid requests aimed at it, scanning consumers from a per-bank rotating pointer.
module rr_bank_scheduler #(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 4,
  parameter int NBANKS      = 2,
  parameter int NPORTS      = 2,
  localparam int REQ_WIDTH  = ADDR_WIDTH + VALUE_WIDTH + 1,
  localparam int CID_WIDTH  = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NCONSUMERS*REQ_WIDTH-1:0]      requests,
  input  logic [NBANKS-1:0]                    bank_ready,
  output logic [NCONSUMERS-1:0]                grant,
  output logic [NBANKS*NPORTS-1:0]             port_valid,
  output logic [NBANKS*NPORTS*ADDR_WIDTH-1:0]  port_addr,
  output logic [NBANKS*NPORTS*VALUE_WIDTH-1:0] port_value,
  output logic [NBANKS*NPORTS*CID_WIDTH-1:0]   port_src
);

  logic [NBANKS*NCONSUMERS-1:0] bank_grant;
  logic [NCONSUMERS-1:0]        grant_next;
  logic [NCONSUMERS-1:0]        grant_reg;

  generate
    for (genvar gb = 0; gb < NBANKS; gb++) begin : g_bank
      logic [CID_WIDTH-1:0]   ptr_reg;
      logic [NCONSUMERS-1:0]  cand;
      logic [NCONSUMERS-1:0]  bgrant;
      logic [NPORTS-1:0]      sel_valid;
      logic [CID_WIDTH-1:0]   sel_src [NPORTS];
      int                     last_idx;
      int                     cnt;
      logic [NPORTS-1:0]      valid_reg;
      logic [ADDR_WIDTH-1:0]  addr_reg  [NPORTS];
      logic [VALUE_WIDTH-1:0] value_reg [NPORTS];
      logic [CID_WIDTH-1:0]   src_reg   [NPORTS];

      always_comb begin
        cand = '0;
        for (int c = 0; c < NCONSUMERS; c++) begin
          cand[c] = requests[c*REQ_WIDTH + REQ_WIDTH - 1] &&
                    ((int'(requests[c*REQ_WIDTH + VALUE_WIDTH +: ADDR_WIDTH]) % NBANKS) == gb);
        end
      end

      // Walk consumers starting at the pointer, filling ports in scan order.
      always_comb begin
        bgrant    = '0;
        sel_valid = '0;
        last_idx  = 0;
        cnt       = 0;
        for (int p = 0; p < NPORTS; p++) sel_src[p] = '0;
        for (int i = 0; i < NCONSUMERS; i++) begin
          int idx;
          idx = (int'(ptr_reg) + i) % NCONSUMERS;
          if (bank_ready[gb] && cand[idx] && cnt < NPORTS) begin
            sel_valid[cnt] = 1'b1;
            sel_src[cnt]   = CID_WIDTH'(idx);
            bgrant[idx]    = 1'b1;
            last_idx       = idx;
            cnt            = cnt + 1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ptr_reg   <= '0;
          valid_reg <= '0;
          for (int p = 0; p < NPORTS; p++) begin
            addr_reg[p]  <= '0;
            value_reg[p] <= '0;
            src_reg[p]   <= '0;
          end
        end else begin
          if (cnt > 0) ptr_reg <= CID_WIDTH'((last_idx + 1) % NCONSUMERS);
          valid_reg <= sel_valid;
          // Idle ports keep their last payload; only port_valid drops.
          for (int p = 0; p < NPORTS; p++) begin
            if (sel_valid[p]) begin
              addr_reg[p]  <= requests[int'(sel_src[p])*REQ_WIDTH + VALUE_WIDTH +: ADDR_WIDTH];
              value_reg[p] <= requests[int'(sel_src[p])*REQ_WIDTH +: VALUE_WIDTH];
              src_reg[p]   <= sel_src[p];
            end
          end
        end
      end

      assign bank_grant[gb*NCONSUMERS +: NCONSUMERS] = bgrant;

      for (genvar gp = 0; gp < NPORTS; gp++) begin : g_port
        assign port_valid[gb*NPORTS + gp]                           = valid_reg[gp];
        assign port_addr[(gb*NPORTS + gp)*ADDR_WIDTH +: ADDR_WIDTH]    = addr_reg[gp];
        assign port_value[(gb*NPORTS + gp)*VALUE_WIDTH +: VALUE_WIDTH] = value_reg[gp];
        assign port_src[(gb*NPORTS + gp)*CID_WIDTH +: CID_WIDTH]       = src_reg[gp];
      end
    end
  endgenerate

  always_comb begin
    grant_next = '0;
    for (int b = 0; b < NBANKS; b++) grant_next = grant_next | bank_grant[b*NCONSUMERS +: NCONSUMERS];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) grant_reg <= '0;
    else        grant_reg <= grant_next;
  end

  assign grant = grant_reg;

endmodule

// File: tb/tb_rr_bank_scheduler.sv
// Directed bench for rr_bank_scheduler at default parameters (4 consumers, 2 banks, 2 ports).
module tb_rr_bank_scheduler;
  localparam int AW = 4, VW = 8, NC = 4, NB = 2, NP = 2;
  localparam int RW = AW + VW + 1, CW = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [NC*RW-1:0]      requests = '0;
  logic [NB-1:0]         bank_ready = '1;
  logic [NC-1:0]         grant;
  logic [NB*NP-1:0]      port_valid;
  logic [NB*NP*AW-1:0]   port_addr;
  logic [NB*NP*VW-1:0]   port_value;
  logic [NB*NP*CW-1:0]   port_src;

  int vectors = 0;
  int miscompares = 0;

  rr_bank_scheduler #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC), .NBANKS(NB), .NPORTS(NP)) dut (
    .clk(clk), .reset(reset), .requests(requests), .bank_ready(bank_ready), .grant(grant),
    .port_valid(port_valid), .port_addr(port_addr), .port_value(port_value), .port_src(port_src)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic v, input logic [AW-1:0] a, input logic [VW-1:0] d);
    requests[c*RW +: RW] = {v, a, d};
  endtask

  function automatic logic [CW-1:0] src_of(input int b, input int p);
    return port_src[(b*NP + p)*CW +: CW];
  endfunction

  function automatic logic [AW-1:0] addr_of(input int b, input int p);
    return port_addr[(b*NP + p)*AW +: AW];
  endfunction

  function automatic logic [VW-1:0] value_of(input int b, input int p);
    return port_value[(b*NP + p)*VW +: VW];
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    requests = '0;
    bank_ready = '1;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < NC; c++) set_req(c, 1'b1, AW'(c + 1), VW'(8'h30 + c));
    step();
    step();
    vectors++;
    if (grant !== 4'b0000 || port_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl grant=%b port_valid=%b required 0000/0000", grant, port_valid);
    end
    vectors++;
    if (port_addr !== '0 || port_value !== '0 || port_src !== '0) begin
      miscompares++;
      $display("FAIL reset_data addr=%h value=%h src=%h required all zero", port_addr, port_value, port_src);
    end
    reset = 1'b1;
    requests = '0;
    set_req(2, 1'b1, 4'h6, 8'hA5);
    step();
    requests = '0;
    $display("reset_first_grant: grant=%b port_valid=%b", grant, port_valid);
    vectors++;
    if (grant !== 4'b0100 || port_valid !== 4'b0001) begin
      miscompares++;
      $display("FAIL first_grant grant=%b port_valid=%b required 0100/0001", grant, port_valid);
    end
    vectors++;
    if (addr_of(0, 0) !== 4'h6 || value_of(0, 0) !== 8'hA5 || src_of(0, 0) !== 2'd2) begin
      miscompares++;
      $display("FAIL first_port addr=%h value=%h src=%0d required 6/a5/2", addr_of(0, 0), value_of(0, 0), src_of(0, 0));
    end
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] exp_g [3];
    logic [CW-1:0] exp_s0 [3];
    logic [CW-1:0] exp_s1 [3];
    exp_g  = '{4'b0011, 4'b1100, 4'b0011};
    exp_s0 = '{2'd0, 2'd2, 2'd0};
    exp_s1 = '{2'd1, 2'd3, 2'd1};
    apply_reset();
    for (int c = 0; c < NC; c++) set_req(c, 1'b1, AW'(2 * c), VW'(8'h10 + c));
    for (int k = 0; k < 3; k++) begin
      step();
      $display("round_robin cycle %0d: grant=%b src=%0d,%0d", k + 1, grant, src_of(0, 0), src_of(0, 1));
      vectors++;
      if (grant !== exp_g[k] || port_valid !== 4'b0011 || src_of(0, 0) !== exp_s0[k] || src_of(0, 1) !== exp_s1[k]) begin
        miscompares++;
        $display("FAIL round_robin_%0d grant=%b valid=%b src=%0d,%0d required %b/0011/%0d,%0d",
                 k + 1, grant, port_valid, src_of(0, 0), src_of(0, 1), exp_g[k], exp_s0[k], exp_s1[k]);
      end
    end
    vectors++;
    if (addr_of(0, 1) !== 4'h2 || value_of(0, 1) !== 8'h11) begin
      miscompares++;
      $display("FAIL round_robin_payload addr=%h value=%h required 2/11", addr_of(0, 1), value_of(0, 1));
    end
  endtask

  task automatic split_traffic();
    set_req(0, 1'b1, 4'h0, 8'h20);
    set_req(1, 1'b1, 4'h1, 8'h21);
    set_req(2, 1'b1, 4'h4, 8'h22);
    set_req(3, 1'b1, 4'h3, 8'h23);
  endtask

  task automatic test_split();
    apply_reset();
    split_traffic();
    step();
    requests = '0;
    $display("split: grant=%b port_valid=%b src=%h", grant, port_valid, port_src);
    vectors++;
    if (grant !== 4'b1111 || port_valid !== 4'b1111) begin
      miscompares++;
      $display("FAIL split_ctrl grant=%b valid=%b required 1111/1111", grant, port_valid);
    end
    vectors++;
    if (src_of(0, 0) !== 2'd0 || src_of(0, 1) !== 2'd2 || src_of(1, 0) !== 2'd1 || src_of(1, 1) !== 2'd3) begin
      miscompares++;
      $display("FAIL split_src src=%0d,%0d,%0d,%0d required 0,2,1,3", src_of(0, 0), src_of(0, 1), src_of(1, 0), src_of(1, 1));
    end
    vectors++;
    if (addr_of(1, 1) !== 4'h3 || value_of(1, 0) !== 8'h21) begin
      miscompares++;
      $display("FAIL split_payload addr=%h value=%h required 3/21", addr_of(1, 1), value_of(1, 0));
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    split_traffic();
    bank_ready = 2'b01;
    step();
    $display("backpressure stalled: grant=%b port_valid=%b", grant, port_valid);
    vectors++;
    if (grant !== 4'b0101 || port_valid !== 4'b0011) begin
      miscompares++;
      $display("FAIL bp_stall grant=%b valid=%b required 0101/0011", grant, port_valid);
    end
    set_req(0, 1'b0, 4'h0, 8'h00);
    set_req(2, 1'b0, 4'h0, 8'h00);
    bank_ready = 2'b11;
    step();
    requests = '0;
    $display("backpressure released: grant=%b port_valid=%b", grant, port_valid);
    vectors++;
    if (grant !== 4'b1010 || port_valid !== 4'b1100 || src_of(1, 0) !== 2'd1 || src_of(1, 1) !== 2'd3) begin
      miscompares++;
      $display("FAIL bp_release grant=%b valid=%b src=%0d,%0d required 1010/1100/1,3",
               grant, port_valid, src_of(1, 0), src_of(1, 1));
    end
    vectors++;
    if (addr_of(0, 1) !== 4'h4 || value_of(0, 1) !== 8'h22) begin
      miscompares++;
      $display("FAIL bp_hold addr=%h value=%h required 4/22", addr_of(0, 1), value_of(0, 1));
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    set_req(2, 1'b1, 4'h2, 8'h40);
    step();
    requests = '0;
    set_req(0, 1'b1, 4'h8, 8'h50);
    set_req(3, 1'b1, 4'hA, 8'h53);
    step();
    $display("wrap: grant=%b src=%0d,%0d", grant, src_of(0, 0), src_of(0, 1));
    vectors++;
    if (grant !== 4'b1001 || src_of(0, 0) !== 2'd3 || src_of(0, 1) !== 2'd0 || addr_of(0, 0) !== 4'hA) begin
      miscompares++;
      $display("FAIL wrap grant=%b src=%0d,%0d addr=%h required 1001/3,0/a",
               grant, src_of(0, 0), src_of(0, 1), addr_of(0, 0));
    end
    for (int c = 0; c < NC; c++) set_req(c, 1'b1, AW'(2 * c), VW'(c));
    step();
    requests = '0;
    $display("wrap follow-up: grant=%b src=%0d,%0d", grant, src_of(0, 0), src_of(0, 1));
    vectors++;
    if (grant !== 4'b0110 || src_of(0, 0) !== 2'd1 || src_of(0, 1) !== 2'd2) begin
      miscompares++;
      $display("FAIL wrap_ptr grant=%b src=%0d,%0d required 0110/1,2", grant, src_of(0, 0), src_of(0, 1));
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int c = 0; c < NC; c++) set_req(c, 1'b1, AW'(2 * c), VW'(8'h60 + c));
    step();
    vectors++;
    if (grant !== 4'b0011) begin
      miscompares++;
      $display("FAIL async_pre grant=%b required 0011", grant);
    end
    #3;
    reset = 1'b0;
    #1;
    $display("async reset asserted: grant=%b port_valid=%b src=%h", grant, port_valid, port_src);
    vectors++;
    if (grant !== 4'b0000 || port_valid !== 4'b0000 || port_src !== '0 || port_addr !== '0) begin
      miscompares++;
      $display("FAIL async_clear grant=%b valid=%b src=%h addr=%h required all zero", grant, port_valid, port_src, port_addr);
    end
    #1;
    reset = 1'b1;
    step();
    requests = '0;
    $display("async reset released: grant=%b src=%0d,%0d", grant, src_of(0, 0), src_of(0, 1));
    vectors++;
    if (grant !== 4'b0011 || src_of(0, 0) !== 2'd0 || src_of(0, 1) !== 2'd1) begin
      miscompares++;
      $display("FAIL async_restart grant=%b src=%0d,%0d required 0011/0,1", grant, src_of(0, 0), src_of(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_split();
    test_backpressure();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
